fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 66 ++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: D-stage redirect/control inputs and fetched-instruction outputs.
// clk and reset stay as plain ports on the fetch unit.
interface fetch_unit_if;
  logic        stall;
  logic        IntReq;
  logic        eretD;
  logic [31:0] EPC;
  logic [1:0]  PCsel_D;
  logic        br_taken;
  logic [15:0] i16_D;
  logic [25:0] i26_D;
  logic [31:0] PC8_D;
  logic [31:0] rs_D;
  logic [31:0] IR;
  logic [31:0] PC8;
  logic [31:0] PC;
  logic [4:0]  ExcCode;
  logic        BD;
  logic [31:0] fetch_cnt;

  modport master (
    output stall, IntReq, eretD, EPC, PCsel_D, br_taken,
    output i16_D, i26_D, PC8_D, rs_D,
    input  IR, PC8, PC, ExcCode, BD, fetch_cnt
  );

  modport slave (
    input  stall, IntReq, eretD, EPC, PCsel_D, br_taken,
    input  i16_D, i26_D, PC8_D, rs_D,
    output IR, PC8, PC, ExcCode, BD, fetch_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, next-PC select, zero-latency ROM read, AdEL check.
// ROM image covers 0x3000-0x4FFC and is supplied through ROM_INIT.
module fetch_unit #(
  parameter logic [31:0] ROM_INIT [2048] = '{default: 32'h0}
) (
  input  logic clk,
  input  logic reset,
  fetch_unit_if.slave bus
);

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] PC_EXC   = 32'h0000_4180;
  localparam logic [31:0] PC_LAST  = 32'h0000_4FFC;

  logic [31:0] r_pc  = PC_RESET;
  logic [31:0] r_cnt = '0;

  logic [31:0] w_pc4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_npc;
  logic [10:0] w_idx;
  logic        w_adel;

  assign w_pc4    = r_pc + 32'd4;
  assign w_br_tgt = (bus.PC8_D - 32'd4)
                  + {{14{bus.i16_D[15]}}, bus.i16_D, 2'b00};

  always_comb begin
    w_npc = w_pc4;
    unique case (bus.PCsel_D)
      2'd0: w_npc = w_pc4;
      2'd1: w_npc = bus.br_taken ? w_br_tgt : w_pc4;
      2'd2: w_npc = {bus.PC8_D[31:28], bus.i26_D, 2'b00};
      2'd3: w_npc = bus.rs_D;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= PC_RESET;
      r_cnt <= '0;
    end else if (bus.IntReq) begin
      r_pc <= PC_EXC;
    end else if (bus.eretD) begin
      r_pc <= bus.EPC;
      if (!bus.stall) r_cnt <= r_cnt + 32'd1;
    end else if (!bus.stall) begin
      r_pc  <= w_npc;
      r_cnt <= r_cnt + 32'd1;
    end
  end

  // (PC - 0x3000)[12:2] folded into an 11-bit subtract
  assign w_idx  = r_pc[12:2] - 11'h400;
  assign w_adel = (r_pc[1:0] != 2'b00)
               || (r_pc < PC_RESET)
               || (r_pc > PC_LAST);

  assign bus.PC        = r_pc;
  assign bus.PC8       = r_pc + 32'd8;
  assign bus.IR        = w_adel ? 32'h0 : ROM_INIT[w_idx];
  assign bus.ExcCode   = w_adel ? 5'd4 : 5'd0;
  assign bus.BD        = (bus.PCsel_D != 2'd0);
  assign bus.fetch_cnt = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential, branch, jump, stall,
// interrupt, eret and address-error cases against hand-computed values.
module tb_fetch_unit;

  localparam logic [31:0] ROM_IMG [2048] = '{
    0:       32'h2401_0001,
    1:       32'h2402_0002,
    2:       32'h2403_0003,
    3:       32'h2404_0004,
    8:       32'h1000_0008,
    16:      32'h3C01_0040,
    11'h460: 32'h4200_0018,
    11'h7FF: 32'hDEAD_BEEF,
    default: 32'h0
  };

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;

  fetch_unit_if bus();

  fetch_unit #(.ROM_INIT(ROM_IMG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    bus.stall    = 1'b0;
    bus.IntReq   = 1'b0;
    bus.eretD    = 1'b0;
    bus.EPC      = '0;
    bus.PCsel_D  = 2'd0;
    bus.br_taken = 1'b0;
    bus.i16_D    = '0;
    bus.i26_D    = '0;
    bus.PC8_D    = '0;
    bus.rs_D     = '0;
    #1;
    chk("t0_pc", bus.PC, 32'h3000);
    chk("t0_cnt", bus.fetch_cnt, 32'h0);

    reset = 1'b1;
    step();
    chk("rst_pc", bus.PC, 32'h3000);
    chk("rst_pc8", bus.PC8, 32'h3008);
    chk("rst_exc", {27'b0, bus.ExcCode}, 32'h0);
    chk("rst_cnt", bus.fetch_cnt, 32'h0);
    chk("rst_ir", bus.IR, 32'h2401_0001);
    chk("rst_bd", {31'b0, bus.BD}, 32'h0);
    reset = 1'b0;

    step();
    chk("seq1_pc", bus.PC, 32'h3004);
    chk("seq1_ir", bus.IR, 32'h2402_0002);
    step();
    chk("seq2_pc", bus.PC, 32'h3008);
    step();
    chk("seq3_pc", bus.PC, 32'h300C);
    chk("seq3_ir", bus.IR, 32'h2404_0004);
    chk("seq3_cnt", bus.fetch_cnt, 32'd3);

    bus.PCsel_D  = 2'd1;
    bus.PC8_D    = 32'h3010;
    bus.i16_D    = 16'hFFFE;
    bus.br_taken = 1'b1;
    #1;
    chk("bt_bd", {31'b0, bus.BD}, 32'h1);
    step();
    chk("bt_pc", bus.PC, 32'h3004);
    chk("bt_cnt", bus.fetch_cnt, 32'd4);

    bus.br_taken = 1'b0;
    #1;
    chk("bn_bd", {31'b0, bus.BD}, 32'h1);
    step();
    chk("bn_pc", bus.PC, 32'h3008);
    chk("bn_cnt", bus.fetch_cnt, 32'd5);

    bus.PCsel_D = 2'd3;
    bus.rs_D    = 32'h3020;
    step();
    chk("jr_pc", bus.PC, 32'h3020);
    chk("jr_ir", bus.IR, 32'h1000_0008);
    chk("jr_cnt", bus.fetch_cnt, 32'd6);

    bus.PCsel_D = 2'd0;
    bus.stall   = 1'b1;
    step();
    chk("st1_pc", bus.PC, 32'h3020);
    chk("st1_cnt", bus.fetch_cnt, 32'd6);
    step();
    chk("st2_pc", bus.PC, 32'h3020);
    chk("st2_cnt", bus.fetch_cnt, 32'd6);

    bus.IntReq = 1'b1;
    step();
    chk("int_pc", bus.PC, 32'h4180);
    chk("int_cnt", bus.fetch_cnt, 32'd6);
    chk("int_ir", bus.IR, 32'h4200_0018);
    chk("int_exc", {27'b0, bus.ExcCode}, 32'h0);

    bus.IntReq  = 1'b0;
    bus.stall   = 1'b0;
    bus.PCsel_D = 2'd3;
    bus.rs_D    = 32'h3002;
    step();
    chk("mis_pc", bus.PC, 32'h3002);
    chk("mis_exc", {27'b0, bus.ExcCode}, 32'd4);
    chk("mis_ir", bus.IR, 32'h0);
    chk("mis_cnt", bus.fetch_cnt, 32'd7);

    bus.rs_D = 32'h5000;
    step();
    chk("hi_pc", bus.PC, 32'h5000);
    chk("hi_exc", {27'b0, bus.ExcCode}, 32'd4);
    chk("hi_ir", bus.IR, 32'h0);

    bus.rs_D = 32'h4FFC;
    step();
    chk("top_exc", {27'b0, bus.ExcCode}, 32'h0);
    chk("top_ir", bus.IR, 32'hDEAD_BEEF);

    bus.rs_D = 32'h2FFC;
    step();
    chk("lo_exc", {27'b0, bus.ExcCode}, 32'd4);
    chk("lo_cnt", bus.fetch_cnt, 32'd10);

    bus.PCsel_D = 2'd0;
    bus.eretD   = 1'b1;
    bus.EPC     = 32'h3040;
    bus.stall   = 1'b1;
    step();
    chk("eret_pc", bus.PC, 32'h3040);
    chk("eret_ir", bus.IR, 32'h3C01_0040);
    chk("eret_exc", {27'b0, bus.ExcCode}, 32'h0);
    chk("eret_cnt", bus.fetch_cnt, 32'd10);

    bus.eretD  = 1'b0;
    bus.stall  = 1'b0;
    reset      = 1'b1;
    bus.IntReq = 1'b1;
    step();
    chk("rint_pc", bus.PC, 32'h3000);
    chk("rint_cnt", bus.fetch_cnt, 32'h0);

    reset       = 1'b0;
    bus.IntReq  = 1'b0;
    bus.PCsel_D = 2'd2;
    bus.PC8_D   = 32'h3008;
    bus.i26_D   = 26'h0000C10;
    #1;
    chk("j_bd", {31'b0, bus.BD}, 32'h1);
    step();
    chk("j_pc", bus.PC, 32'h3040);
    chk("j_cnt", bus.fetch_cnt, 32'd1);

    bus.PCsel_D = 2'd0;
    #1;
    chk("seq_bd", {31'b0, bus.BD}, 32'h0);
    chk("j_pc8", bus.PC8, 32'h3048);
    step();
    chk("post_pc", bus.PC, 32'h3044);
    chk("post_cnt", bus.fetch_cnt, 32'd2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
